// File: rtl/sec_pkg.sv
// Shared definitions for the Gray-sequence controller: FSM encoding and Gray table.
package sec_pkg;

  localparam int unsigned GRAY_W   = 3;
  localparam int unsigned GRAY_LEN = 8;
  localparam int unsigned STATE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    REPOSO = 2'b00,
    CORRE  = 2'b01,
    PAUSA  = 2'b10,
    FIN    = 2'b11
  } estado_t;

  // Forward Gray order; entry 0 is the LSB slice (000), entry 7 is 100.
  localparam logic [GRAY_LEN-1:0][GRAY_W-1:0] GRAY_SEQ = {
    3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000
  };

endpackage : sec_pkg

// File: rtl/sig_gray.sv
// Next-Gray-value lookup.
//   actual    : current 3-bit Gray code
//   dir       : 1 = step forward in the table, 0 = step backward (both wrap)
//   siguiente : neighbouring Gray code in the chosen direction
module sig_gray
  import sec_pkg::*;
(
  input  logic [GRAY_W-1:0] actual,
  input  logic              dir,
  output logic [GRAY_W-1:0] siguiente
);

  // Locate actual in the table and pick its neighbour; 3-bit index math wraps naturally.
  always_comb begin
    siguiente = actual;
    for (int unsigned i = 0; i < GRAY_LEN; i++) begin
      if (GRAY_SEQ[3'(i)] == actual) begin
        siguiente = dir ? GRAY_SEQ[3'(i + 1)] : GRAY_SEQ[3'(i + GRAY_LEN - 1)];
      end
    end
  end

endmodule : sig_gray

// File: rtl/sec_gray_ctrl.sv
// Gray-sequence stepping controller.
//   CLK, RST_N : clock, asynchronous active-low reset
//   Start      : run request, honoured only in REPOSO (latches Dir and Pasos)
//   Dir        : 1 = forward Gray, 0 = reverse Gray
//   Pasos      : step count, 0 means 2^CUENTA_W steps
//   Pausa      : level hold, no stepping while high
//   Abortar    : cancel a running sequence, keeps the current code
//   Estados    : current Gray code (persists across runs)
//   Ocupado    : high in CORRE and PAUSA
//   Listo      : one-cycle completion pulse (FIN)
module sec_gray_ctrl
  import sec_pkg::*;
#(
  parameter int unsigned CUENTA_W = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                Start,
  input  logic                Dir,
  input  logic [CUENTA_W-1:0] Pasos,
  input  logic                Pausa,
  input  logic                Abortar,
  output logic [GRAY_W-1:0]   Estados,
  output logic                Ocupado,
  output logic                Listo
);

  // One extra bit so the counter can hold the full 2^CUENTA_W run length.
  localparam int unsigned          CNT_W    = CUENTA_W + 1;
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(1) << CUENTA_W;
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  estado_t             state_q, state_d;
  logic [GRAY_W-1:0]   estados_q, estados_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic [GRAY_W-1:0]   siguiente;
  logic                step_en;
  logic                load_en;

  sig_gray u_sig_gray (
    .actual    (estados_q),
    .dir       (dir_q),
    .siguiente (siguiente)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= REPOSO;
      estados_q <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      estados_q <= estados_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

  // Next-state logic; Abortar has priority over Pausa and over the final step.
  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    load_en = 1'b0;
    case (state_q)
      REPOSO: begin
        if (Start) begin
          state_d = CORRE;
          load_en = 1'b1;
        end
      end
      CORRE: begin
        if (Abortar) begin
          state_d = REPOSO;
        end else if (Pausa) begin
          state_d = PAUSA;
        end else begin
          step_en = 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = FIN;
          end
        end
      end
      PAUSA: begin
        if (Abortar) begin
          state_d = REPOSO;
        end else if (!Pausa) begin
          state_d = CORRE;
        end
      end
      FIN:     state_d = REPOSO;
      default: state_d = REPOSO;
    endcase
  end

  // Datapath next values: load on accepted Start, advance on a step.
  always_comb begin
    estados_d = estados_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    if (load_en) begin
      dir_d = Dir;
      cnt_d = (Pasos == '0) ? CNT_FULL : CNT_W'(Pasos);
    end else if (step_en) begin
      estados_d = siguiente;
      cnt_d     = cnt_q - CNT_ONE;
    end
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    Ocupado = 1'b0;
    Listo   = 1'b0;
    case (state_q)
      CORRE, PAUSA: Ocupado = 1'b1;
      FIN:          Listo   = 1'b1;
      default: begin
        Ocupado = 1'b0;
        Listo   = 1'b0;
      end
    endcase
  end

  assign Estados = estados_q;

endmodule : sec_gray_ctrl

// File: doc/sec_gray_ctrl.md
SEC_GRAY_CTRL -- requirements
Module: sec_gray_ctrl

Interface
REQ-001 Parameter: CUENTA_W, default 3, width of the step-count input Pasos.
REQ-002 Port: CLK  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous and active-low.
REQ-004 Port: Start  input  1  request to run a sequence; sampled only in REPOSO.
REQ-005 Port: Dir  input  1  direction, latched with Start: 1 = forward Gray, 0 = reverse Gray.
REQ-006 Port: Pasos  input  CUENTA_W  number of steps, latched with Start; value 0 means 2^CUENTA_W steps.
REQ-007 Port: Pausa  input  1  level hold; while high, no step is taken.
REQ-008 Port: Abortar  input  1  terminate the running sequence.
REQ-009 Port: Estados  output  3  current 3-bit Gray state.
REQ-010 Port: Ocupado  output  1  high in CORRE and PAUSA.
REQ-011 Port: Listo  output  1  one-cycle completion pulse, high only in FIN.

Function
REQ-012 The Gray order SHALL be 000>001>011>010>110>111>101>100>000 forward and the exact inverse in reverse, wrapping in both directions.
REQ-013 The FSM SHALL have exactly four states: REPOSO, CORRE, PAUSA and FIN.
REQ-014 REPOSO: Start=1 at edge k SHALL latch Dir and Pasos into a step counter (0 loads 2^CUENTA_W) and enter CORRE; Ocupado=1 from edge k.
REQ-015 CORRE: each edge with Pausa=0 and Abortar=0 SHALL advance Estados one Gray step and decrement the counter.
REQ-016 The edge that takes the final step SHALL enter FIN, so N steps complete at edge k+N and Listo is high for the cycle k+N to k+N+1.
REQ-017 FIN SHALL return to REPOSO on the next edge unconditionally.
REQ-018 CORRE with Pausa=1 SHALL enter PAUSA without stepping; PAUSA with Pausa=0 SHALL return to CORRE without stepping on that edge.
REQ-019 Throughout PAUSA, Estados and the counter SHALL hold.
REQ-020 Abortar=1 in CORRE or PAUSA SHALL go to REPOSO on that edge, take no step, keep Estados, and never assert Listo; Abortar beats Pausa and beats the final step.
REQ-021 Start outside REPOSO SHALL be ignored, including in FIN; Abortar in REPOSO or FIN SHALL be ignored.
REQ-022 Estados SHALL persist across sequences; each new run starts from the current value.
REQ-023 Outputs SHALL be registered or decoded from the state register only, with no combinational path from the inputs.

Reset
REQ-024 RST_N low SHALL immediately force REPOSO, Estados=000, counter=0, Ocupado=0 and Listo=0, regardless of CLK.
REQ-025 Reset asserted mid-sequence SHALL discard the sequence; after release the block SHALL wait in REPOSO for a new Start.
REQ-026 The first edge after RST_N rises SHALL behave as a normal REPOSO edge.

Structure
REQ-027 The FSM state encodings (REPOSO=00, CORRE=01, PAUSA=10, FIN=11) and the Gray table constants SHALL live in the shared package sec_pkg.
REQ-028 The next-Gray-value logic SHALL be the combinational sub-module sig_gray, with inputs actual[2:0] and dir and output siguiente[2:0].
REQ-029 RTL size SHALL be 120-400 lines, sub-module included.

Verification
REQ-030 Reset, then Start with Dir=1, Pasos=3 -> Estados 001, 011, 010 on three consecutive edges; Listo high one cycle; Ocupado low in FIN.
REQ-031 From Estados=010, Start with Dir=0, Pasos=2 -> Estados 011 then 001; Listo pulse; Estados remains 001 in REPOSO.
REQ-032 From 000, Dir=1, Pasos=0 -> 8 steps through the full cycle ending at 000; Listo occurs at edge k+8.
REQ-033 Dir=1, Pasos=4, Pausa held high 3 cycles after the first step -> Estados holds 001 for 3 cycles; total Listo delay = 4+3+1 edges.
REQ-034 Abortar and Pausa both high on the final-step edge -> REPOSO, no step, no Listo; a Start during FIN of another run is ignored.
REQ-035 RST_N pulsed low asynchronously mid-run, between edges -> Estados=000, Ocupado=0 immediately; no Listo after release.
